des_round_ctrl: RTL and testbench

- Read-domain sequencer for an iterative (one-round-per-cycle) DES datapath fed by the async input FIFO.
- Pops one 64-bit block from the FIFO, loads the round register, then drives 16 round enables with the round-key index: forward order for encryption, reversed for decryption.
- Presents the result with a valid/ready handshake.
- Arbitrates S-box edit requests so that S-box contents never change while a block is in flight.

---
 rtl/des_round_ctrl.sv | 125 ++++++++++++
 tb/tb_des_round_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/des_round_ctrl.sv
// Read-domain sequencer for a one-round-per-cycle DES datapath: pops a FIFO block,
// runs the round enables with the key index, hands the result off, and serialises S-box edits.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | nothing in flight; edit request wins over a pending block
//   S_POP   | one-cycle FIFO pop strobe
//   S_WAIT  | waiting out the remaining FIFO read latency
//   S_LOAD  | load FIFO data into L/R, capture mode, clear round counter
//   S_ROUND | one datapath round per cycle
//   S_DONE  | result valid until downstream accepts it
//   S_EDIT  | one-cycle S-box write, acknowledged to the requester
module des_round_ctrl #(
    parameter int NUM_ROUNDS  = 16,
    parameter int FIFO_RD_LAT = 1,
    localparam int CW = $clog2(NUM_ROUNDS)
) (
    input  logic          rd_clk,
    input  logic          rd_rst,
    input  logic          empty,
    input  logic          mode,
    input  logic          out_ready,
    input  logic          edit_req,
    output logic          rd_incr,
    output logic          load,
    output logic          round_en,
    output logic [CW-1:0] round_idx,
    output logic [CW-1:0] key_idx,
    output logic          last_round,
    output logic          o_valid,
    output logic          sbox_we,
    output logic          edit_ack,
    output logic          busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_POP, S_WAIT, S_LOAD, S_ROUND, S_DONE, S_EDIT
    } state_t;

    localparam int WW = (FIFO_RD_LAT > 1) ? $clog2(FIFO_RD_LAT) : 1;
    localparam logic [WW-1:0] WAIT_INIT = WW'((FIFO_RD_LAT > 1) ? FIFO_RD_LAT - 2 : 0);
    localparam logic [CW-1:0] LAST_IDX  = CW'(NUM_ROUNDS - 1);

    state_t        state;
    state_t        state_nx;
    state_t        next_job;
    logic [CW-1:0] rnd_cnt;
    logic [WW-1:0] wait_cnt;
    logic          mode_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state    <= S_IDLE;
            rnd_cnt  <= '0;
            wait_cnt <= '0;
            mode_q   <= 1'b1;
        end else begin
            state <= state_nx;
            case (state)
                S_POP:   wait_cnt <= WAIT_INIT;
                S_WAIT:  if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
                S_LOAD: begin
                    mode_q  <= mode;
                    rnd_cnt <= '0;
                end
                // counter parks on the last index; LOAD clears it for the next block
                S_ROUND: if (rnd_cnt != LAST_IDX) rnd_cnt <= rnd_cnt + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        next_job = S_IDLE;
        if (edit_req)
            next_job = S_EDIT;
        else if (!empty)
            next_job = S_POP;
    end

    always_comb begin
        state_nx   = state;
        rd_incr    = 1'b0;
        load       = 1'b0;
        round_en   = 1'b0;
        round_idx  = '0;
        key_idx    = '0;
        last_round = 1'b0;
        o_valid    = 1'b0;
        sbox_we    = 1'b0;
        edit_ack   = 1'b0;
        case (state)
            S_IDLE: state_nx = next_job;
            S_POP: begin
                rd_incr  = 1'b1;
                state_nx = (FIFO_RD_LAT == 1) ? S_LOAD : S_WAIT;
            end
            S_WAIT: if (wait_cnt == '0) state_nx = S_LOAD;
            S_LOAD: begin
                load     = 1'b1;
                state_nx = S_ROUND;
            end
            S_ROUND: begin
                round_en   = 1'b1;
                round_idx  = rnd_cnt;
                key_idx    = mode_q ? rnd_cnt : (LAST_IDX - rnd_cnt);
                last_round = (rnd_cnt == LAST_IDX);
                if (rnd_cnt == LAST_IDX) state_nx = S_DONE;
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (out_ready) state_nx = next_job;
            end
            S_EDIT: begin
                sbox_we  = 1'b1;
                edit_ack = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: directed scenarios then random traffic, every cycle compared
// against a per-operation timeline model (op kind + cycles since the op started).
module tb_des_round_ctrl;
    localparam int NR        = 16;
    localparam int LAT       = 1;
    localparam int VALID_AGE = LAT + NR + 1;
    localparam int OP_NONE   = 0;
    localparam int OP_BLK    = 1;
    localparam int OP_EDIT   = 2;

    logic       rd_clk = 1'b0;
    logic       rd_rst, empty, mode, out_ready, edit_req;
    logic       rd_incr, load, round_en, last_round, o_valid, sbox_we, edit_ack, busy;
    logic [3:0] round_idx, key_idx;

    des_round_ctrl #(.NUM_ROUNDS(NR), .FIFO_RD_LAT(LAT)) dut (
        .rd_clk     (rd_clk),
        .rd_rst     (rd_rst),
        .empty      (empty),
        .mode       (mode),
        .out_ready  (out_ready),
        .edit_req   (edit_req),
        .rd_incr    (rd_incr),
        .load       (load),
        .round_en   (round_en),
        .round_idx  (round_idx),
        .key_idx    (key_idx),
        .last_round (last_round),
        .o_valid    (o_valid),
        .sbox_we    (sbox_we),
        .edit_ack   (edit_ack),
        .busy       (busy)
    );

    always #5 rd_clk = ~rd_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, phase = 0, ptick = 0;
    int fifo_cnt = 0, last_pop = -1, stall_cnt = 0;
    int dut_xfers = 0, m_xfers = 0;
    bit did_rst = 0, prev_valid = 0;
    int m_op = OP_NONE, m_age = 0;
    bit m_mode = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, want %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {rd_incr, load, round_en, round_idx, key_idx, last_round,
                o_valid, sbox_we, edit_ack, busy};
    endfunction

    // Outputs derived from where the current operation sits on its timeline.
    function automatic logic [15:0] expect_vec();
        logic rd, ld, ren, last, ov, we;
        int   idx, key;
        rd = 0; ld = 0; ren = 0; last = 0; ov = 0; idx = 0; key = 0;
        if (m_op == OP_BLK) begin
            rd  = (m_age == 0);
            ld  = (m_age == LAT);
            ren = (m_age > LAT) && (m_age <= LAT + NR);
            if (ren) begin
                idx = m_age - LAT - 1;
                key = m_mode ? idx : NR - 1 - idx;
            end
            last = ren && (idx == NR - 1);
            ov   = (m_age >= VALID_AGE);
        end
        we = (m_op == OP_EDIT);
        return {rd, ld, ren, 4'(idx), 4'(key), last, ov, we, we, (m_op != OP_NONE)};
    endfunction

    task automatic start_next();
        m_age = 0;
        if (edit_req)    m_op = OP_EDIT;
        else if (!empty) m_op = OP_BLK;
        else             m_op = OP_NONE;
    endtask

    task automatic model_step();
        if (rd_rst) begin
            m_op  = OP_NONE;
            m_age = 0;
        end else begin
            case (m_op)
                OP_NONE: start_next();
                OP_BLK: begin
                    if (m_age >= VALID_AGE) begin
                        if (out_ready) begin
                            m_xfers++;
                            start_next();
                        end
                    end else begin
                        if (m_age == LAT) m_mode = mode;
                        m_age++;
                    end
                end
                default: m_op = OP_NONE;
            endcase
        end
    endtask

    task automatic drive_inputs();
        rd_rst = 1'b0;
        case (phase)
            0: begin
                mode      = 1'b1;
                out_ready = 1'b1;
            end
            1: begin
                mode = 1'($urandom);
                if (o_valid) begin
                    out_ready = (stall_cnt >= 10);
                    stall_cnt++;
                end else begin
                    out_ready = 1'b0;
                end
            end
            2: begin
                mode      = 1'($urandom);
                out_ready = 1'b1;
                if (round_en && round_idx == 5 && !edit_req) edit_req = 1'b1;
                if (ptick == 40) begin
                    edit_req = 1'b1;
                    fifo_cnt++;
                end
            end
            3: begin
                mode      = 1'($urandom);
                out_ready = 1'b1;
                if (round_en && round_idx == 8 && !did_rst) begin
                    rd_rst  = 1'b1;
                    did_rst = 1'b1;
                end
            end
            default: begin
                mode      = 1'($urandom);
                out_ready = ($urandom_range(3) != 0);
                if ($urandom_range(7) == 0) fifo_cnt++;
                if (!edit_req && !edit_ack && $urandom_range(39) == 0) edit_req = 1'b1;
                if ($urandom_range(199) == 0) rd_rst = 1'b1;
            end
        endcase
        empty = (fifo_cnt == 0);
    endtask

    task automatic tick();
        @(negedge rd_clk);
        cyc++;
        ptick++;
        chk("outputs", 32'(dut_vec()), 32'(expect_vec()));
        chk("pop_with_we", 32'(rd_incr & sbox_we), 32'd0);
        if (rd_incr) begin
            chk("pop_nonempty", 32'(empty), 32'd0);
            if (phase == 0 && last_pop >= 0) chk("pop_gap", cyc - last_pop, NR + LAT + 2);
            last_pop = cyc;
            if (fifo_cnt > 0) fifo_cnt--;
        end
        if (o_valid && !prev_valid) chk("latency", cyc - last_pop, 1 + LAT + NR);
        prev_valid = o_valid;
        if (edit_ack) edit_req = 1'b0;
        drive_inputs();
        if (o_valid && out_ready && !rd_rst) dut_xfers++;
        model_step();
    endtask

    initial begin
        rd_rst    = 1'b1;
        empty     = 1'b1;
        mode      = 1'b1;
        out_ready = 1'b1;
        edit_req  = 1'b0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("reset_state", 32'(dut_vec()), 32'd0);

        phase = 0; ptick = 0; fifo_cnt = 3;
        repeat (70) tick();

        phase = 1; ptick = 0; fifo_cnt += 2; stall_cnt = 0;
        repeat (70) tick();

        phase = 2; ptick = 0; fifo_cnt += 1;
        repeat (80) tick();

        phase = 3; ptick = 0; fifo_cnt += 2; did_rst = 0;
        repeat (60) tick();

        phase = 4; ptick = 0;
        repeat (3000) tick();

        chk("transfers", dut_xfers, m_xfers);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
